// File: rtl/concat_seq_pkg.sv
// concat_seq_pkg: shared state encoding, default widths and the MSB-first pattern merge
package concat_seq_pkg;
  localparam int DEF_WORD_W = 25;
  localparam int DEF_PAT_W = 8;
  localparam int DEF_LEN_W = $clog2(DEF_PAT_W) + 1;
  localparam int DEF_REP_W = 5;
  localparam int DEF_FILL_W = $clog2(DEF_WORD_W + 1);
  localparam int SPAN = DEF_WORD_W + DEF_PAT_W;
  typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_e;
  function automatic logic [DEF_WORD_W-1:0] insert_bits(
    input logic [DEF_WORD_W-1:0] w,
    input logic [DEF_PAT_W-1:0] pat,
    input logic [DEF_LEN_W-1:0] len,
    input logic [DEF_FILL_W-1:0] pos
  );
    logic [DEF_LEN_W-1:0] lc;
    logic [DEF_PAT_W-1:0] m;
    logic [SPAN-1:0] v;
    int sh;
    lc = len > DEF_LEN_W'(DEF_PAT_W) ? DEF_LEN_W'(DEF_PAT_W) : len;
    m = pat & ~({DEF_PAT_W{1'b1}} << lc);
    sh = SPAN - int'(pos) - int'(lc);
    v = {{DEF_WORD_W{1'b0}}, m} << sh;
    return w | v[SPAN-1:DEF_PAT_W];
  endfunction
endpackage

// File: rtl/concat_pattern_sequencer.sv
// concat_pattern_sequencer: expands run-length pattern segments MSB-first into a tie-off word
module concat_pattern_sequencer import concat_seq_pkg::*; #(
  parameter int WORD_W = DEF_WORD_W,
  parameter int PAT_W = DEF_PAT_W,
  parameter int LEN_W = $clog2(PAT_W) + 1,
  parameter int REP_W = DEF_REP_W
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           seg_valid,
  output logic                           seg_ready,
  input  logic [PAT_W-1:0]               seg_pat,
  input  logic [LEN_W-1:0]               seg_len,
  input  logic [REP_W-1:0]               seg_rep,
  input  logic                           seg_last,
  output logic [WORD_W-1:0]              word,
  output logic                           word_valid,
  input  logic                           word_ready,
  output logic                           err_ovf,
  output logic                           err_short,
  output logic [$clog2(WORD_W+1)-1:0]    fill_cnt
);
  localparam int FILL_W = $clog2(WORD_W + 1);
  localparam int SUM_W = $clog2(WORD_W + PAT_W + 1);
  localparam logic [FILL_W-1:0] FULL = FILL_W'(WORD_W);
  localparam logic [SUM_W-1:0] FULL_S = SUM_W'(WORD_W);
  localparam logic [LEN_W-1:0] PMAX = LEN_W'(PAT_W);
  state_e state_q, state_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [FILL_W-1:0] fill_q, fill_d, fill_nxt;
  logic [SUM_W-1:0] fill_sum;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [LEN_W-1:0] len_q, len_d, in_len;
  logic [REP_W-1:0] rep_q, rep_d;
  logic last_q, last_d, ovf_q, ovf_d, short_q, short_d;
  always_comb begin
    fill_sum = SUM_W'(fill_q) + SUM_W'(len_q);
    fill_nxt = fill_sum > FULL_S ? FULL : fill_sum[FILL_W-1:0];
    in_len = seg_len > PMAX ? PMAX : seg_len;
    state_d = state_q;
    word_d = word_q;
    fill_d = fill_q;
    pat_d = pat_q;
    len_d = len_q;
    rep_d = rep_q;
    last_d = last_q;
    ovf_d = ovf_q;
    short_d = short_q;
    case (state_q)
      IDLE: if (seg_valid) begin
        pat_d = seg_pat;
        len_d = in_len;
        rep_d = seg_rep;
        last_d = seg_last;
        if (in_len == '0 || seg_rep == '0) begin
          state_d = seg_last ? DONE : IDLE;
          short_d = seg_last && fill_q < FULL;
        end else state_d = EXPAND;
      end
      EXPAND: begin
        word_d = insert_bits(word_q, pat_q, len_q, fill_q);
        fill_d = fill_nxt;
        ovf_d = ovf_q | (fill_sum > FULL_S);
        rep_d = rep_q - REP_W'(1);
        if (rep_q == REP_W'(1)) begin
          state_d = last_q ? DONE : IDLE;
          short_d = last_q && fill_nxt < FULL;
        end
      end
      DONE: if (word_ready) begin
        state_d = IDLE;
        word_d = '0;
        fill_d = '0;
        ovf_d = 1'b0;
        short_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      word_q <= '0;
      fill_q <= '0;
      pat_q <= '0;
      len_q <= '0;
      rep_q <= '0;
      last_q <= 1'b0;
      ovf_q <= 1'b0;
      short_q <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q <= word_d;
      fill_q <= fill_d;
      pat_q <= pat_d;
      len_q <= len_d;
      rep_q <= rep_d;
      last_q <= last_d;
      ovf_q <= ovf_d;
      short_q <= short_d;
    end
  end
  assign seg_ready = state_q == IDLE && !rst;
  assign word_valid = state_q == DONE;
  assign word = word_q;
  assign fill_cnt = fill_q;
  assign err_ovf = ovf_q;
  assign err_short = short_q;
endmodule
